// File: rtl/inst_cache.sv
// rtl/inst_cache.sv - direct-mapped instruction cache with refill FSM, flush and perf counters
//
// Purpose: one-word-per-line direct-mapped cache between fetch and a slow
// read-only instruction memory. Hits return one cycle after acceptance;
// misses refill over a req/ack memory port, then return the fetched word.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   fetch request handshake, pc = word address
//   inst_valid/inst       one-cycle result pulse, inst holds between pulses
//   mem_req/mem_addr      refill request (level) and address, held until ack
//   mem_ack/mem_data      one-cycle refill data return
//   flush                 invalidate every line in one cycle
//   hit_count/miss_count  saturating performance counters
module inst_cache #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int LINES  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] pc,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  typedef enum logic {S_IDLE, S_REFILL} state_t;

  state_t state, state_nxt;

  // Valid bits live in flops so flush clears them all in a single edge;
  // tag and data arrays need no reset because valid gates every lookup.
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  // Remembers a flush seen earlier in this refill so the fill is not
  // marked valid even though the flush pulse has already gone.
  logic flush_seen;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             hit;
  logic             accept;
  logic             do_hit;
  logic             do_miss;
  logic             do_fill;

  assign req_idx  = pc[IDX_W-1:0];
  assign req_tag  = pc[ADDR_W-1:IDX_W];
  assign fill_idx = mem_addr[IDX_W-1:0];
  assign fill_tag = mem_addr[ADDR_W-1:IDX_W];
  assign hit      = valid[req_idx] && (tag_mem[req_idx] == req_tag);

  assign accept  = req_valid && req_ready;
  assign do_hit  = accept && hit;
  assign do_miss = accept && !hit;
  assign do_fill = (state == S_REFILL) && mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // mem_req is decoded from state so an asynchronous reset drops it at once.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_req   = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = !flush;
        if (req_valid && !flush && !hit) begin
          state_nxt = S_REFILL;
        end
      end
      S_REFILL: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid      <= '0;
      flush_seen <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= '0;
      mem_addr   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      inst_valid <= do_hit || do_fill;

      if (do_hit) begin
        inst <= data_mem[req_idx];
      end else if (do_fill) begin
        inst <= mem_data;
      end

      if (do_miss) begin
        mem_addr <= pc;
      end

      if (flush) begin
        valid <= '0;
      end else if (do_fill && !flush_seen) begin
        valid[fill_idx] <= 1'b1;
      end

      if (do_fill) begin
        flush_seen <= 1'b0;
      end else if ((state == S_REFILL) && flush) begin
        flush_seen <= 1'b1;
      end

      if (do_hit && (hit_count != '1)) begin
        hit_count <= hit_count + CNT_W'(1);
      end
      if (do_miss && (miss_count != '1)) begin
        miss_count <= miss_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_fill) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mem_data;
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// tb/tb_inst_cache.sv - self-checking bench for inst_cache (default and 4-bit counter instances)
//
// Purpose: drives fetch and memory ports, keeps a queue of expected
// instructions and a counter model, and checks both instances.
// Ports: none (top-level bench).
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [15:0] pc;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic        flush;

  logic        req_ready,  req_ready4;
  logic        inst_valid, inst_valid4;
  logic [15:0] inst,       inst4;
  logic        mem_req,    mem_req4;
  logic [15:0] mem_addr,   mem_addr4;
  logic [15:0] hit_count,  miss_count;
  logic [3:0]  hit_count4, miss_count4;

  int checks   = 0;
  int failures = 0;
  int exp_hit  = 0;
  int exp_miss = 0;
  logic [15:0] exp_q[$];

  logic [15:0] pre_data [11];

  always #5 clk = ~clk;

  inst_cache dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .pc(pc), .inst_valid(inst_valid), .inst(inst), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data), .flush(flush),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  inst_cache #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready4),
    .pc(pc), .inst_valid(inst_valid4), .inst(inst4), .mem_req(mem_req4),
    .mem_addr(mem_addr4), .mem_ack(mem_ack), .mem_data(mem_data), .flush(flush),
    .hit_count(hit_count4), .miss_count(miss_count4)
  );

  function automatic logic [15:0] sat16(input int v);
    logic [31:0] t;
    t = v;
    return (v > 65535) ? 16'hFFFF : t[15:0];
  endfunction

  function automatic logic [3:0] sat4(input int v);
    logic [31:0] t;
    t = v;
    return (v > 15) ? 4'hF : t[3:0];
  endfunction

  // Scoreboard: every inst_valid pulse pops one expected instruction.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (inst_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_inst_valid inst=%h expected=no pulse", inst);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (inst !== e) begin
            failures++;
            $display("FAIL inst_data got=%h expected=%h", inst, e);
          end
        end
      end
      checks++;
      if (inst_valid4 !== inst_valid || inst4 !== inst) begin
        failures++;
        $display("FAIL dut4_result valid=%b inst=%h expected valid=%b inst=%h",
                 inst_valid4, inst4, inst_valid, inst);
      end
    end
  end

  // Presents one request for one cycle starting at posedge+1; returns at next posedge+1.
  task automatic issue(input logic [15:0] a, input bit is_hit, input logic [15:0] d);
    req_valid = 1'b1;
    pc = a;
    if (is_hit) begin
      exp_q.push_back(d);
      exp_hit++;
    end else begin
      exp_miss++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (mem_req !== !is_hit || (!is_hit && mem_addr !== a)) begin
      failures++;
      $display("FAIL issue_%h mem_req=%b mem_addr=%h expected mem_req=%b mem_addr=%h",
               a, mem_req, mem_addr, !is_hit, a);
    end
  endtask

  // Waits for mem_req (bounded), holds lat cycles, then acks one word.
  task automatic serve(input logic [15:0] d, input int lat);
    int n;
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL serve_timeout mem_req=%b expected=1", mem_req);
      return;
    end
    for (int i = 0; i < lat; i++) begin
      @(posedge clk); #1;
      checks++;
      if (mem_req !== 1'b1 || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL refill_hold mem_req=%b req_ready=%b expected 1/0", mem_req, req_ready);
      end
    end
    mem_ack = 1'b1;
    mem_data = d;
    exp_q.push_back(d);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL after_ack mem_req=%b req_ready=%b expected 0/1", mem_req, req_ready);
    end
  endtask

  task automatic test_counters(input string tag);
    checks++;
    if (hit_count !== sat16(exp_hit) || miss_count !== sat16(exp_miss)) begin
      failures++;
      $display("FAIL counters_%s hit=%0d miss=%0d expected hit=%0d miss=%0d",
               tag, hit_count, miss_count, sat16(exp_hit), sat16(exp_miss));
    end
    checks++;
    if (hit_count4 !== sat4(exp_hit) || miss_count4 !== sat4(exp_miss)) begin
      failures++;
      $display("FAIL counters4_%s hit=%0d miss=%0d expected hit=%0d miss=%0d",
               tag, hit_count4, miss_count4, sat4(exp_hit), sat4(exp_miss));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    pc = '0;
    mem_ack = 1'b0;
    mem_data = '0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (inst_valid !== 1'b0 || inst !== 16'h0 || mem_req !== 1'b0 || mem_addr !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs iv=%b inst=%h mreq=%b maddr=%h expected 0/0/0/0",
               inst_valid, inst, mem_req, mem_addr);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready req_ready=%b expected=1", req_ready);
    end
    test_counters("reset");
    @(posedge clk); #1;
  endtask

  task automatic test_cold_miss_hit();
    issue(16'h0003, 1'b0, 16'h0);
    serve(16'h5119, 1);
    test_counters("cold_miss");
    issue(16'h0003, 1'b1, 16'h5119);
    test_counters("cold_hit");
    // Stray ack in IDLE must produce nothing.
    mem_ack = 1'b1;
    mem_data = 16'hDEAD;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || inst !== 16'h5119) begin
      failures++;
      $display("FAIL stray_ack mem_req=%b inst=%h expected 0/5119", mem_req, inst);
    end
  endtask

  task automatic test_conflict();
    issue(16'h0013, 1'b0, 16'h0);
    serve(16'hA009, 0);
    issue(16'h0003, 1'b0, 16'h0);
    serve(16'h5119, 2);
    checks++;
    if (miss_count !== 16'd3) begin
      failures++;
      $display("FAIL conflict_miss_count got=%0d expected=3", miss_count);
    end
    test_counters("conflict");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 11; i++) begin
      if (i != 3) begin
        issue(16'(i), 1'b0, 16'h0);
        serve(pre_data[i], i % 3);
      end
    end
    for (int i = 0; i < 11; i++) begin
      req_valid = 1'b1;
      pc = 16'(i);
      exp_q.push_back(pre_data[i]);
      exp_hit++;
      checks++;
      if (req_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready_%0d req_ready=%b expected=1", i, req_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (inst_valid !== 1'b1 || mem_req !== 1'b0) begin
        failures++;
        $display("FAIL b2b_stream_%0d inst_valid=%b mem_req=%b expected 1/0", i, inst_valid, mem_req);
      end
    end
    req_valid = 1'b0;
    test_counters("b2b");
  endtask

  task automatic test_flush();
    flush = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_ready req_ready=%b expected=0", req_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    issue(16'h0005, 1'b0, 16'h0);
    serve(16'hA009, 0);
    // Flush in the middle of a refill: data returns, line stays invalid.
    issue(16'h0007, 1'b0, 16'h0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    serve(16'h1234, 1);
    issue(16'h0007, 1'b0, 16'h0);
    serve(16'h1235, 0);
    issue(16'h0007, 1'b1, 16'h1235);
    test_counters("flush");
  endtask

  task automatic test_reset_mid_refill();
    issue(16'h0009, 1'b0, 16'h0);
    #2;
    rst_n = 1'b0;
    #1;
    exp_hit = 0;
    exp_miss = 0;
    checks++;
    if (mem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 16'h0 || mem_addr !== 16'h0) begin
      failures++;
      $display("FAIL reset_async mreq=%b iv=%b inst=%h maddr=%h expected 0/0/0/0",
               mem_req, inst_valid, inst, mem_addr);
    end
    test_counters("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_release req_ready=%b mem_req=%b expected 1/0", req_ready, mem_req);
    end
    issue(16'h0009, 1'b0, 16'h0);
    serve(16'h1808, 0);
    test_counters("after_reset");
  endtask

  task automatic test_saturation();
    issue(16'h0002, 1'b0, 16'h0);
    serve(16'h0008, 0);
    for (int i = 0; i < 20; i++) begin
      issue(16'h0002, 1'b1, 16'h0008);
    end
    checks++;
    if (hit_count4 !== 4'hF || hit_count !== 16'd20) begin
      failures++;
      $display("FAIL saturation hit4=%h hit16=%0d expected F/20", hit_count4, hit_count);
    end
    test_counters("saturation");
  endtask

  initial begin
    pre_data = '{16'h500A, 16'h50BC, 16'h0008, 16'h5119, 16'h0810, 16'hA009,
                 16'hC000, 16'hB500, 16'hFF00, 16'h1808, 16'h00F0};
    test_reset();
    test_cold_miss_hit();
    test_conflict();
    test_back_to_back();
    test_flush();
    test_reset_mid_refill();
    test_saturation();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
